i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target_if.sv | 24 ++
 rtl/i2c_target.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// Bus and register-side signal bundle for the I2C target.
// The target is the slave modport; the environment driving the bus uses master.
interface i2c_target_if;
  logic       SDA_I;
  logic       SDA_O;
  logic       SDA_E;
  logic       SCL_I;
  logic [7:0] REG_ADDR;
  logic [7:0] REG_WDATA;
  logic       REG_WE;
  logic [7:0] REG_RDATA;
  logic       REG_RE;
  logic       BUSY;

  modport slave (
    input  SDA_I, SCL_I, REG_RDATA,
    output SDA_O, SDA_E, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY
  );

  modport master (
    output SDA_I, SCL_I, REG_RDATA,
    input  SDA_O, SDA_E, REG_ADDR, REG_WDATA, REG_WE, REG_RE, BUSY
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target with a byte-wide register port: first written byte sets the
// register index, further bytes write and auto-increment; reads stream from the index.
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h29
) (
  input  logic          CLK,
  input  logic          RST,
  i2c_target_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_e;

  logic       sda_s1_q, sda_s2_q, sda_p_q;
  logic       scl_s1_q, scl_s2_q, scl_p_q;
  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic       phase_q, phase_d;
  logic       upd_q, upd_d;
  logic       sda_e_q, sda_e_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       busy_q, busy_d;

  logic       scl_rise_c, scl_fall_c, start_c, stop_c, last_bit_c;
  logic [7:0] rx_byte_c;

  // Bus conditions from the synchronized lines and their one-cycle-old copies
  always_comb begin
    scl_rise_c = scl_s2_q & ~scl_p_q;
    scl_fall_c = ~scl_s2_q & scl_p_q;
    start_c    = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
    stop_c     = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
    rx_byte_c  = {shift_q[6:0], sda_s2_q};
    last_bit_c = (bit_cnt_q == 4'd7);
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    phase_d     = phase_q;
    upd_d       = 1'b0;
    sda_e_d     = sda_e_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;

    // Index advances the cycle after a write strobe
    if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;

    if (start_c) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_e_d   = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      sda_e_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, IGNORE: sda_e_d = 1'b0;

        ADDR: if (scl_rise_c) begin
          shift_d   = rx_byte_c;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit_c) begin
            bit_cnt_d = 4'd0;
            phase_d   = 1'b0;
            if (rx_byte_c[7:1] == ADDRESS) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end

        // shift_q[0] still holds the R/W bit of the address byte
        ADDR_ACK: if (scl_fall_c) begin
          if (!phase_q) begin
            sda_e_d = 1'b1;
            phase_d = 1'b1;
          end else if (shift_q[0]) begin
            shift_d   = bus.REG_RDATA;
            reg_re_d  = 1'b1;
            upd_d     = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = RD;
          end else begin
            sda_e_d    = 1'b0;
            byte_idx_d = 2'd0;
            bit_cnt_d  = 4'd0;
            state_d    = WR;
          end
        end

        WR: if (scl_rise_c) begin
          shift_d   = rx_byte_c;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit_c) begin
            bit_cnt_d = 4'd0;
            phase_d   = 1'b0;
            state_d   = WR_ACK;
            if (byte_idx_q == 2'd0) begin
              reg_addr_d = rx_byte_c;
            end else begin
              reg_wdata_d = rx_byte_c;
              reg_we_d    = 1'b1;
            end
          end
        end

        WR_ACK: if (scl_fall_c) begin
          if (!phase_q) begin
            sda_e_d = 1'b1;
            phase_d = 1'b1;
          end else begin
            sda_e_d   = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WR;
            if (byte_idx_q != 2'd2) byte_idx_d = byte_idx_q + 2'd1;
          end
        end

        // Drive value follows the shift MSB one cycle after each load/shift
        RD: begin
          if (upd_q) sda_e_d = ~shift_q[7];
          if (scl_rise_c) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_c) begin
            if (bit_cnt_q == 4'd8) begin
              sda_e_d = 1'b0;
              phase_d = 1'b0;
              state_d = RD_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              upd_d   = 1'b1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise_c) begin
            if (sda_s2_q) begin
              state_d = IGNORE;
            end else begin
              reg_addr_d = reg_addr_q + 8'd1;
              phase_d    = 1'b1;
            end
          end else if (scl_fall_c && phase_q) begin
            shift_d   = bus.REG_RDATA;
            reg_re_d  = 1'b1;
            upd_d     = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = RD;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronizers idle high so reset looks like a quiet bus
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_p_q     <= 1'b1;
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_p_q     <= 1'b1;
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 4'd0;
      byte_idx_q  <= 2'd0;
      phase_q     <= 1'b0;
      upd_q       <= 1'b0;
      sda_e_q     <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sda_s1_q    <= bus.SDA_I;
      sda_s2_q    <= sda_s1_q;
      sda_p_q     <= sda_s2_q;
      scl_s1_q    <= bus.SCL_I;
      scl_s2_q    <= scl_s1_q;
      scl_p_q     <= scl_s2_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      phase_q     <= phase_d;
      upd_q       <= upd_d;
      sda_e_q     <= sda_e_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.SDA_O     = 1'b0;
  assign bus.SDA_E     = sda_e_q;
  assign bus.REG_ADDR  = reg_addr_q;
  assign bus.REG_WDATA = reg_wdata_q;
  assign bus.REG_WE    = reg_we_q;
  assign bus.REG_RE    = reg_re_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged bus master plus a transaction-level
// model of the register pointer, write log and read data.
module tb_i2c_target;

  localparam logic [6:0] TADDR = 7'h29;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic sda_m = 1'b1;
  logic scl_m = 1'b1;

  i2c_target_if bus ();

  i2c_target #(.ADDRESS(TADDR)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Wired-AND bus; register side returns the inverted index as read data
  assign bus.SCL_I     = scl_m;
  assign bus.SDA_I     = sda_m & ~bus.SDA_E;
  assign bus.REG_RDATA = bus.REG_ADDR ^ 8'hFF;

  int checks = 0;
  int errors = 0;

  logic [15:0] we_log [$];
  logic [15:0] exp_we [$];
  logic [7:0]  mdl_ptr = 8'h00;
  int          re_cnt = 0;
  bit          quiet = 1'b0;
  int          quiet_viol = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.REG_WE) we_log.push_back({bus.REG_ADDR, bus.REG_WDATA});
      if (bus.REG_RE) re_cnt++;
      if (quiet && (bus.SDA_E || bus.REG_WE || bus.REG_RE || bus.BUSY)) quiet_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; clks(4); scl_m = 1'b1; clks(8); scl_m = 1'b0; clks(4);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; clks(4); scl_m = 1'b1; clks(6); b = bus.SDA_I; clks(2);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clks(4); scl_m = 1'b1; clks(6); sda_m = 1'b0; clks(6);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(4); scl_m = 1'b1; clks(6); sda_m = 1'b1; clks(8);
  endtask

  task automatic put_byte(input logic [7:0] b, output bit ack);
    logic nb;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_bit(nb);
    ack = ~nb;
  endtask

  task automatic get_byte(input bit ack, output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      get_bit(x);
      b[i] = x;
    end
    send_bit(~ack);
  endtask

  // START, address+W, data bytes; model: first byte sets pointer, rest write and advance
  task automatic wr_bytes(input logic [6:0] a, input logic [7:0] d[$]);
    bit ack;
    bit hit;
    hit = (a == TADDR);
    i2c_start();
    put_byte({a, 1'b0}, ack);
    chk("addr_ack", 32'(ack), 32'(hit));
    for (int i = 0; i < d.size(); i++) begin
      put_byte(d[i], ack);
      chk("data_ack", 32'(ack), 32'(hit));
      if (hit) begin
        if (i == 0) mdl_ptr = d[i];
        else begin
          exp_we.push_back({mdl_ptr, d[i]});
          mdl_ptr = mdl_ptr + 8'd1;
        end
      end
    end
  endtask

  task automatic chk_writes();
    chk("we_count", 32'(we_log.size()), 32'(exp_we.size()));
    for (int i = 0; i < exp_we.size() && i < we_log.size(); i++)
      chk("we_entry", 32'(we_log[i]), 32'(exp_we[i]));
    we_log.delete();
    exp_we.delete();
    chk("reg_addr", 32'(bus.REG_ADDR), 32'(mdl_ptr));
  endtask

  // Repeated START, address+R, n bytes (ACK all but the last), STOP
  task automatic rd_txn(input int n);
    logic [7:0] b;
    bit ack;
    int re0;
    re0 = re_cnt;
    i2c_start();
    put_byte({TADDR, 1'b1}, ack);
    chk("rd_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      get_byte(i < n - 1, b);
      chk("rd_data", 32'(b), 32'(mdl_ptr ^ 8'hFF));
      if (i < n - 1) mdl_ptr = mdl_ptr + 8'd1;
    end
    chk("busy_before_stop", 32'(bus.BUSY), 32'd1);
    i2c_stop();
    chk("re_count", 32'(re_cnt - re0), 32'(n));
    chk("rd_reg_addr", 32'(bus.REG_ADDR), 32'(mdl_ptr));
    chk("busy_after_stop", 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    logic [7:0] d [$];
    logic [6:0] a;
    int         kind;
    int         n;
    bit         got;

    // Reset state
    clks(3);
    chk("rst_sda_e", 32'(bus.SDA_E), 32'd0);
    chk("rst_we", 32'(bus.REG_WE), 32'd0);
    chk("rst_re", 32'(bus.REG_RE), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_addr", 32'(bus.REG_ADDR), 32'h00);
    chk("rst_wdata", 32'(bus.REG_WDATA), 32'h00);
    chk("rst_sda_o", 32'(bus.SDA_O), 32'd0);
    RST = 1'b0;
    clks(5);

    // Write 0x10 <- A5, 0x11 <- 5A
    d = '{8'h10, 8'hA5, 8'h5A};
    wr_bytes(TADDR, d);
    chk("busy_in_write", 32'(bus.BUSY), 32'd1);
    i2c_stop();
    chk_writes();

    // Set index 0x20, read two bytes through a repeated START
    d = '{8'h20};
    wr_bytes(TADDR, d);
    rd_txn(2);
    chk_writes();

    // Foreign address: bus left alone until STOP
    quiet = 1'b1;
    d = '{8'h11};
    wr_bytes(7'h2A, d);
    i2c_stop();
    quiet = 1'b0;
    chk("foreign_quiet", 32'(quiet_viol), 32'd0);
    chk_writes();

    // Index wraps from 0xFF to 0x00
    d = '{8'hFF, 8'h01, 8'h02};
    wr_bytes(TADDR, d);
    i2c_stop();
    chk_writes();

    // Reset while the target holds the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h52 >> i));
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      got = bus.SDA_E;
    end
    chk("ack_drive_seen", 32'(got), 32'd1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_sda_e", 32'(bus.SDA_E), 32'd0);
    chk("async_rst_busy", 32'(bus.BUSY), 32'd0);
    chk("async_rst_addr", 32'(bus.REG_ADDR), 32'h00);
    scl_m = 1'b1;
    sda_m = 1'b1;
    clks(4);
    RST = 1'b0;
    mdl_ptr = 8'h00;
    clks(6);
    d = '{8'h05, 8'h77};
    wr_bytes(TADDR, d);
    i2c_stop();
    chk_writes();

    // STOP in the middle of a data byte
    d = '{8'h30};
    wr_bytes(TADDR, d);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    i2c_stop();
    chk("midbyte_busy", 32'(bus.BUSY), 32'd0);
    chk("midbyte_sda_e", 32'(bus.SDA_E), 32'd0);
    chk_writes();

    // Randomized mix of writes, reads and foreign-address traffic
    for (int it = 0; it < 10; it++) begin
      kind = int'($urandom_range(0, 2));
      n    = int'($urandom_range(1, 4));
      d.delete();
      d.push_back(8'($urandom));
      if (kind == 0) begin
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        wr_bytes(TADDR, d);
        i2c_stop();
        chk_writes();
      end else if (kind == 1) begin
        wr_bytes(TADDR, d);
        rd_txn(n);
        chk_writes();
      end else begin
        a = 7'($urandom);
        if (a == TADDR) a = a ^ 7'h01;
        quiet = 1'b1;
        wr_bytes(a, d);
        i2c_stop();
        quiet = 1'b0;
        chk("rand_foreign_quiet", 32'(quiet_viol), 32'd0);
        chk_writes();
      end
    end

    chk("final_sda_o", 32'(bus.SDA_O), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
